// File: rtl/pran_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding, completion error codes and the request legality check.
package pran_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } err_t;

   // Illegal width code takes priority over misalignment.
   function automatic err_t check_access(input logic       store,
                                         input logic [2:0] f3,
                                         input logic [1:0] offset);
      logic illegal;
      logic misaligned;
      if (store)
         illegal = !(f3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misaligned = ((f3 == F3_H || f3 == F3_HU) && offset[0]) ||
                   ((f3 == F3_W) && (offset != 2'b00));
      if (illegal)
         return ERR_ILLEGAL;
      else if (misaligned)
         return ERR_MISALIGN;
      else
         return ERR_OK;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
//   mem_req/mem_we     request and write enable
//   mem_addr           word-aligned byte address
//   mem_wstrb/wdata    byte-lane strobes and lane-replicated store data
//   mem_rdata/mem_ack  read word and single-cycle acknowledge
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
//   st_size/st_offset/st_data -> st_strb, st_lanes : store strobe + replication
//   ld_size/ld_offset/ld_word -> ld_data           : load field shifted to bit 0,
//                                                    upper bits zero
// size is funct3[1:0]: 00 byte, 01 half, 10 word.
module lsu_lane_align (
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic [31:0] st_lanes,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shifted;

   always_comb begin
      st_strb  = 4'b1111;
      st_lanes = st_data;
      if (st_size == 2'b00) begin
         st_strb  = 4'b0001 << st_offset;
         st_lanes = {4{st_data[7:0]}};
      end else if (st_size == 2'b01) begin
         st_strb  = 4'b0011 << st_offset;
         st_lanes = {2{st_data[15:0]}};
      end
   end

   always_comb begin
      ld_shifted = ld_word >> {ld_offset, 3'b000};
      if (ld_size == 2'b00)
         ld_data = {24'h0, ld_shifted[7:0]};
      else if (ld_size == 2'b01)
         ld_data = {16'h0, ld_shifted[15:0]};
      else
         ld_data = ld_word;
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request, checks width/alignment, runs a
// single bus access with timeout, and reports completion with an error code.
//   clk, reset        clock and synchronous active-high reset
//   start             request strobe (accepted in IDLE when not busy)
//   is_store, funct3  access type and RV32I width/sign code
//   addr, wdata       byte address and right-justified store data
//   busy, done, err   in-flight flag, completion pulse, completion status
//   read_data_mem     last loaded field, right-justified, zero-filled
//   mem               memory bus (master side)
module load_store_unit
   import pran_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [31:0] read_data_mem,
   load_store_unit_if.master mem
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t      state;
   err_t        pend_err;
   err_t        start_err;
   logic        is_store_q;
   logic [1:0]  size_q;
   logic [1:0]  offset_q;
   logic [CW-1:0] cnt;

   logic        req_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic [3:0]  st_strb;
   logic [31:0] st_lanes;
   logic [31:0] ld_data;

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wstrb = wstrb_q;
   assign mem.mem_wdata = wdata_q;

   // Evaluated on exactly the values captured at acceptance, so the decision
   // equals a check on the registered fields while letting mem_req rise one
   // cycle after start.
   always_comb start_err = check_access(is_store, funct3, addr[1:0]);

   lsu_lane_align u_align (
      .st_size   (funct3[1:0]),
      .st_offset (addr[1:0]),
      .st_data   (wdata),
      .st_strb   (st_strb),
      .st_lanes  (st_lanes),
      .ld_size   (size_q),
      .ld_offset (offset_q),
      .ld_word   (mem.mem_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pend_err      <= ERR_OK;
         is_store_q    <= 1'b0;
         size_q        <= '0;
         offset_q      <= '0;
         cnt           <= '0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wstrb_q       <= '0;
         wdata_q       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= ERR_OK;
         read_data_mem <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (busy) begin
                  // Busy in IDLE only happens on the rejected-request path.
                  state <= ST_RESP;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= pend_err;
               end else if (start) begin
                  busy       <= 1'b1;
                  is_store_q <= is_store;
                  size_q     <= funct3[1:0];
                  offset_q   <= addr[1:0];
                  pend_err   <= start_err;
                  if (start_err == ERR_OK) begin
                     state   <= ST_ACCESS;
                     cnt     <= '0;
                     req_q   <= 1'b1;
                     we_q    <= is_store;
                     addr_q  <= {addr[31:2], 2'b00};
                     wstrb_q <= is_store ? st_strb : 4'b0000;
                     wdata_q <= st_lanes;
                  end
               end
            end
            ST_ACCESS: begin
               if (mem.mem_ack || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state   <= ST_RESP;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wstrb_q <= 4'b0000;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  err     <= mem.mem_ack ? ERR_OK : ERR_TIMEOUT;
                  if (mem.mem_ack && !is_store_q)
                     read_data_mem <= ld_data;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (TIMEOUT_CYCLES=4): each request pushes
// its expected completion (err, read_data_mem, latency) and a monitor pops and
// compares on every done pulse.
module tb_load_store_unit;
   import pran_lsu_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [31:0] read_data_mem;

   load_store_unit_if mif ();

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .is_store      (is_store),
      .funct3        (funct3),
      .addr          (addr),
      .wdata         (wdata),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .read_data_mem (read_data_mem),
      .mem           (mif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
      int unsigned start_cyc;
      int unsigned lat;
   } exp_t;

   exp_t        sbq[$];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned n_done = 0;
   int unsigned n_pushed = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         n_done++;
         if (sbq.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("err", {30'h0, err}, {30'h0, e.err});
            check("read_data_mem", read_data_mem, e.rdata);
            check("latency", cyc - e.start_cyc, e.lat);
         end
      end
   end

   // One request: n_acc ACCESS cycles expected; ack on the last one if give_ack.
   task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input bit exp_req, input int unsigned n_acc, input bit give_ack,
                     input bit extra_start,
                     input logic [3:0] e_strb, input logic [31:0] e_wd,
                     input logic [1:0] e_err, input logic [31:0] e_rd, input int unsigned e_lat);
      exp_t e;
      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      e.err = e_err; e.rdata = e_rd; e.start_cyc = cyc; e.lat = e_lat;
      sbq.push_back(e);
      n_pushed++;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {31'h0, busy}, 32'd1);
      if (exp_req) begin
         for (int unsigned k = 0; k < n_acc; k++) begin
            if (k > 0) @(negedge clk);
            start = (extra_start && k == 1);
            if (extra_start && k == 1) begin
               is_store = 1'b1; funct3 = F3_W; addr = 32'h0000_9990; wdata = 32'h5555_AAAA;
            end
            check("mem_req", {31'h0, mif.mem_req}, 32'd1);
            check("mem_addr", mif.mem_addr, {a[31:2], 2'b00});
            check("mem_we", {31'h0, mif.mem_we}, {31'h0, st});
            check("mem_wstrb", {28'h0, mif.mem_wstrb}, {28'h0, e_strb});
            if (st) check("mem_wdata", mif.mem_wdata, e_wd);
            if (give_ack && k == n_acc - 1) begin
               mif.mem_ack = 1'b1; mif.mem_rdata = rd;
            end
         end
         @(negedge clk);
         start = 1'b0;
         mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
         check("mem_req_after", {31'h0, mif.mem_req}, 32'd0);
      end else begin
         check("no_mem_req", {31'h0, mif.mem_req}, 32'd0);
      end
      for (int i = 0; i < 10; i++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      if (sbq.size() != 0) begin
         check("done_wait", 32'd0, 32'd1);
         sbq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_err", {30'h0, err}, 32'd0);
      check("rst_mem_req", {31'h0, mif.mem_req}, 32'd0);
      check("rst_mem_we", {31'h0, mif.mem_we}, 32'd0);
      check("rst_wstrb", {28'h0, mif.mem_wstrb}, 32'd0);
      check("rst_rdm", read_data_mem, 32'd0);
      reset = 1'b0;

      //  st  f3      addr          wdata         rdata         req n  ack extra strb     e_wdata       err           rdm           lat
      op(0, F3_BU, 32'h0000_1003, 32'h0,        32'hA1B2_C3D4, 1, 1, 1, 0, 4'b0000, 32'h0,        ERR_OK,       32'h0000_00A1, 2);
      op(1, F3_H,  32'h0000_2002, 32'h0000_BEEF, 32'h0,        1, 1, 1, 0, 4'b1100, 32'hBEEF_BEEF, ERR_OK,       32'h0000_00A1, 2);
      op(0, F3_W,  32'h0000_3001, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        ERR_MISALIGN, 32'h0000_00A1, 2);
      op(0, 3'b011, 32'h0000_3001, 32'h0,       32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        ERR_ILLEGAL,  32'h0000_00A1, 2);
      op(0, 3'b111, 32'h0000_3003, 32'h0,       32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        ERR_ILLEGAL,  32'h0000_00A1, 2);
      op(0, F3_W,  32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 1, TO, 0, 0, 4'b0000, 32'h0,       ERR_TIMEOUT,  32'h0000_00A1, TO + 1);
      op(0, F3_H,  32'h0000_6002, 32'h0,        32'h8765_4321, 1, 4, 1, 1, 4'b0000, 32'h0,        ERR_OK,       32'h0000_8765, 5);
      repeat (4) @(negedge clk);

      // Reset in the second ACCESS cycle aborts with no done.
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h0000_5000;
      @(negedge clk);
      start = 1'b0;
      check("abort_req_first", {31'h0, mif.mem_req}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_mem_req", {31'h0, mif.mem_req}, 32'd0);
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_rdm", read_data_mem, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      op(0, F3_W,  32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 1, 2, 1, 0, 4'b0000, 32'h0,        ERR_OK,       32'hDEAD_BEEF, 3);
      op(1, F3_B,  32'h0000_7003, 32'h1234_56AB, 32'h0,        1, 1, 1, 0, 4'b1000, 32'hABAB_ABAB, ERR_OK,       32'hDEAD_BEEF, 2);
      op(0, F3_B,  32'h0000_7001, 32'h0,        32'h1122_3344, 1, 1, 1, 0, 4'b0000, 32'h0,        ERR_OK,       32'h0000_0033, 2);
      op(1, F3_BU, 32'h0000_7000, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        ERR_ILLEGAL,  32'h0000_0033, 2);
      op(1, F3_H,  32'h0000_7001, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        ERR_MISALIGN, 32'h0000_0033, 2);
      op(1, F3_W,  32'h0000_8000, 32'hCAFE_F00D, 32'h0,        1, 1, 1, 0, 4'b1111, 32'hCAFE_F00D, ERR_OK,       32'h0000_0033, 2);
      op(0, F3_HU, 32'h0000_8002, 32'h0,        32'hF00D_1234, 1, 1, 1, 0, 4'b0000, 32'h0,        ERR_OK,       32'h0000_F00D, 2);

      repeat (5) @(negedge clk);
      check("done_count", n_done, n_pushed);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
